// File: rtl/atm_pkg.sv
// ATM controller shared definitions: widths, state/operation encodings and
// the power-on contents of the account database.
package atm_pkg;

  localparam int NUM_ACCOUNTS = 10;
  localparam int MAX_PIN      = 9999;

  localparam int PIN_W = 14;
  localparam int BAL_W = 32;
  localparam int AMT_W = 16;
  localparam int ACC_W = 4;
  localparam int OP_W  = 3;

  // FSM state encoding; the operation states share the operation code values
  typedef enum logic [2:0] {
    ST_ACCOUNT    = 3'd0,
    ST_PIN        = 3'd1,
    ST_MENU       = 3'd2,
    ST_BALANCE    = 3'd3,
    ST_WITHDRAW   = 3'd4,
    ST_DEPOSIT    = 3'd5,
    ST_CHANGE_PIN = 3'd6,
    ST_IDLE       = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_BALANCE    = 3'd3;
  localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd4;
  localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd5;
  localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd6;

  // Entry i holds account number i+1
  localparam logic [PIN_W-1:0] INIT_PIN [NUM_ACCOUNTS] = '{
    14'd1234, 14'd2345, 14'd3456, 14'd4567, 14'd5678,
    14'd6789, 14'd7890, 14'd8901, 14'd9012, 14'd7123
  };

  localparam logic [BAL_W-1:0] INIT_BAL [NUM_ACCOUNTS] = '{
    32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000,
    32'd6000, 32'd7000, 32'd8000, 32'd9000, 32'd10000
  };

  // Account numbers are 1-based; 0 and anything above the table are invalid
  function automatic logic isAccountNumber(input logic [ACC_W-1:0] acc);
    return (acc >= 4'd1) && (acc <= ACC_W'(NUM_ACCOUNTS));
  endfunction

endpackage

// File: rtl/atm_if.sv
// Front-end <-> ATM controller bundle: transaction request fields going in,
// result and FSM state coming back out.
interface atm_if;
  import atm_pkg::*;

  logic [OP_W-1:0]  operation;
  logic [ACC_W-1:0] acc_num;
  logic [PIN_W-1:0] pin;
  logic [PIN_W-1:0] newPin;
  logic [AMT_W-1:0] amount;
  logic             language;
  logic [BAL_W-1:0] balance;
  logic             success;
  logic [2:0]       state;

  modport master (
    output operation, acc_num, pin, newPin, amount, language,
    input  balance, success, state
  );

  modport slave (
    input  operation, acc_num, pin, newPin, amount, language,
    output balance, success, state
  );

endinterface

// File: rtl/atm_account_db.sv
// Account database: per-account PIN and balance registers that reload their
// power-on values on reset, combinational read and one synchronous write
// port addressed by a 0-based index.
// Optional feature: ATM_LOCKOUT_EN adds a per-account wrong-PIN counter and
// lock flag.
module atm_account_db
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] i_idx,
  output logic [PIN_W-1:0] o_pin,
  output logic [BAL_W-1:0] o_bal,
  input  logic             i_balWe,
  input  logic [BAL_W-1:0] i_wrBal,
  input  logic             i_pinWe,
  input  logic [PIN_W-1:0] i_wrPin
`ifdef ATM_LOCKOUT_EN
  ,
  input  logic             i_pinFail,
  input  logic             i_pinOk,
  output logic             o_locked
`endif
);

  logic [PIN_W-1:0] r_pin [NUM_ACCOUNTS];
  logic [BAL_W-1:0] r_bal [NUM_ACCOUNTS];
  logic             w_inRange;

  assign w_inRange = (i_idx < ACC_W'(NUM_ACCOUNTS));
  assign o_pin     = w_inRange ? r_pin[i_idx] : '0;
  assign o_bal     = w_inRange ? r_bal[i_idx] : '0;

  // Storage: reset restores the initial table, otherwise apply the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_pin[i] <= INIT_PIN[i];
        r_bal[i] <= INIT_BAL[i];
      end
    end else if (w_inRange) begin
      if (i_balWe) r_bal[i_idx] <= i_wrBal;
      if (i_pinWe) r_pin[i_idx] <= i_wrPin;
    end
  end

`ifdef ATM_LOCKOUT_EN
  logic [1:0]              r_failCnt [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] r_locked;

  assign o_locked = w_inRange ? r_locked[i_idx] : 1'b0;

  // Lockout: the third consecutive wrong PIN locks the account until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_failCnt[i] <= 2'd0;
      end
      r_locked <= '0;
    end else if (w_inRange) begin
      if (i_pinOk) begin
        r_failCnt[i_idx] <= 2'd0;
      end else if (i_pinFail) begin
        if (r_failCnt[i_idx] == 2'd2) begin
          r_locked[i_idx]  <= 1'b1;
          r_failCnt[i_idx] <= 2'd0;
        end else begin
          r_failCnt[i_idx] <= r_failCnt[i_idx] + 2'd1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/atm.sv
// ATM transaction controller top: captures a request in IDLE, then walks
// ACCOUNT -> PIN -> operation -> IDLE, updating balance/success on the
// execute or reject step.
// Optional feature: ATM_LOCKOUT_EN (wrong-PIN account lockout).
module atm
  import atm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  atm_if.slave  bus
);

  state_t           r_state;
  state_t           w_nextState;

  logic [OP_W-1:0]  r_op;
  logic [ACC_W-1:0] r_acc;
  logic [PIN_W-1:0] r_pin;
  logic [PIN_W-1:0] r_newPin;
  logic [AMT_W-1:0] r_amount;
  logic             r_language;

  logic [BAL_W-1:0] r_balance;
  logic             r_success;

  logic [ACC_W-1:0] w_idx;
  logic [PIN_W-1:0] w_dbPin;
  logic [BAL_W-1:0] w_dbBal;
  logic             w_balWe;
  logic [BAL_W-1:0] w_wrBal;
  logic             w_pinWe;
  logic             w_accOk;
  logic             w_pinMatch;
  logic [BAL_W-1:0] w_amtExt;
  logic [BAL_W:0]   w_depSum;
  logic             w_newPinOk;
  logic             w_outWe;
  logic [BAL_W-1:0] w_outBal;
  logic             w_outSucc;
  logic             w_unusedLang;

`ifdef ATM_LOCKOUT_EN
  logic w_locked;
  logic w_pinFail;
  logic w_pinOk;
`endif

  // Language is carried with the transaction for the display only
  assign w_unusedLang = r_language;

  assign w_idx      = r_acc - 4'd1;
  assign w_pinMatch = (r_pin == w_dbPin);
  assign w_amtExt   = {{(BAL_W-AMT_W){1'b0}}, r_amount};
  assign w_depSum   = {1'b0, w_dbBal} + {1'b0, w_amtExt};
  assign w_newPinOk = (r_newPin <= PIN_W'(MAX_PIN)) && (r_newPin != w_dbPin);
`ifdef ATM_LOCKOUT_EN
  assign w_accOk    = isAccountNumber(r_acc) && !w_locked;
`else
  assign w_accOk    = isAccountNumber(r_acc);
`endif

  atm_account_db u_db (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .o_pin     (w_dbPin),
    .o_bal     (w_dbBal),
    .i_balWe   (w_balWe),
    .i_wrBal   (w_wrBal),
    .i_pinWe   (w_pinWe),
    .i_wrPin   (r_newPin)
`ifdef ATM_LOCKOUT_EN
    ,
    .i_pinFail (w_pinFail),
    .i_pinOk   (w_pinOk),
    .o_locked  (w_locked)
`endif
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Request capture: inputs are only sampled while sitting in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_acc      <= '0;
      r_pin      <= '0;
      r_newPin   <= '0;
      r_amount   <= '0;
      r_language <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_op       <= bus.operation;
      r_acc      <= bus.acc_num;
      r_pin      <= bus.pin;
      r_newPin   <= bus.newPin;
      r_amount   <= bus.amount;
      r_language <= bus.language;
    end
  end

  // Result registers hold until the next execute or reject step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_balance <= '0;
      r_success <= 1'b0;
    end else if (w_outWe) begin
      r_balance <= w_outBal;
      r_success <= w_outSucc;
    end
  end

  // Next state, database writes and result values
  always_comb begin
    w_nextState = r_state;
    w_balWe     = 1'b0;
    w_wrBal     = w_dbBal;
    w_pinWe     = 1'b0;
    w_outWe     = 1'b0;
    w_outBal    = r_balance;
    w_outSucc   = 1'b0;
`ifdef ATM_LOCKOUT_EN
    w_pinFail   = 1'b0;
    w_pinOk     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_nextState = ST_ACCOUNT;
      end
      ST_ACCOUNT: begin
        if (w_accOk) begin
          w_nextState = ST_PIN;
        end else begin
          w_outWe     = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_PIN: begin
        if (w_pinMatch) begin
`ifdef ATM_LOCKOUT_EN
          w_pinOk = 1'b1;
`endif
          case (r_op)
            OP_BALANCE:    w_nextState = ST_BALANCE;
            OP_WITHDRAW:   w_nextState = ST_WITHDRAW;
            OP_DEPOSIT:    w_nextState = ST_DEPOSIT;
            OP_CHANGE_PIN: w_nextState = ST_CHANGE_PIN;
            default:       w_nextState = ST_MENU;
          endcase
        end else begin
`ifdef ATM_LOCKOUT_EN
          w_pinFail = 1'b1;
`endif
          w_outWe     = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_MENU: begin
        w_outWe     = 1'b1;
        w_nextState = ST_IDLE;
      end
      ST_BALANCE: begin
        w_outWe     = 1'b1;
        w_outBal    = w_dbBal;
        w_outSucc   = 1'b1;
        w_nextState = ST_IDLE;
      end
      ST_WITHDRAW: begin
        w_outWe  = 1'b1;
        w_outBal = w_dbBal;
        if (w_amtExt <= w_dbBal) begin
          w_balWe   = 1'b1;
          w_wrBal   = w_dbBal - w_amtExt;
          w_outBal  = w_dbBal - w_amtExt;
          w_outSucc = 1'b1;
        end
        w_nextState = ST_IDLE;
      end
      ST_DEPOSIT: begin
        w_outWe  = 1'b1;
        w_outBal = w_dbBal;
        if (!w_depSum[BAL_W]) begin
          w_balWe   = 1'b1;
          w_wrBal   = w_depSum[BAL_W-1:0];
          w_outBal  = w_depSum[BAL_W-1:0];
          w_outSucc = 1'b1;
        end
        w_nextState = ST_IDLE;
      end
      ST_CHANGE_PIN: begin
        w_outWe  = 1'b1;
        w_outBal = w_dbBal;
        if (w_newPinOk) begin
          w_pinWe   = 1'b1;
          w_outSucc = 1'b1;
        end
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign bus.balance = r_balance;
  assign bus.success = r_success;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_atm.sv
// Self-checking bench for the ATM controller: a reference model computes the
// expected result of every request, queues it, and the result is popped and
// compared when the FSM returns to IDLE.
module tb_atm;

`ifdef ATM_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  typedef struct {
    logic [31:0] bal;
    logic        succ;
    int          edges;
    logic        menu;
  } exp_t;

  logic clk;
  logic rst;

  atm_if bus ();

  atm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sbQ [$];
  int          nCompared;
  int          nMismatched;

  logic [13:0] mPin  [1:15];
  logic [31:0] mBal  [1:15];
  int          mFail [1:15];
  bit          mLock [1:15];
  logic [31:0] mOutBal;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    logic [13:0] initPin [10];
    initPin = '{14'd1234, 14'd2345, 14'd3456, 14'd4567, 14'd5678,
                14'd6789, 14'd7890, 14'd8901, 14'd9012, 14'd7123};
    for (int k = 1; k <= 15; k++) begin
      mPin[k]  = (k <= 10) ? initPin[k-1] : 14'd0;
      mBal[k]  = (k <= 10) ? 32'(k * 1000) : 32'd0;
      mFail[k] = 0;
      mLock[k] = 1'b0;
    end
    mOutBal = 32'd0;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput({tag, ".state"},   32'(bus.state), 32'd7);
    checkOutput({tag, ".balance"}, bus.balance,    32'd0);
    checkOutput({tag, ".success"}, 32'(bus.success), 32'd0);
  endtask

  // Compute the expected outcome from the model, drive one request, follow
  // the FSM back to IDLE and compare against the queued expectation
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] acc,
                               input logic [13:0] p, input logic [13:0] np, input logic [15:0] amt);
    exp_t        e;
    exp_t        got;
    logic [32:0] sum;
    int          edges;
    logic        sawMenu;

    e.menu = 1'b0;
    e.succ = 1'b0;
    e.bal  = mOutBal;
    if (acc < 4'd1 || acc > 4'd10 || (LOCKOUT && mLock[acc])) begin
      e.edges = 2;
    end else if (p != mPin[acc]) begin
      e.edges = 3;
      if (LOCKOUT) begin
        mFail[acc]++;
        if (mFail[acc] == 3) begin
          mLock[acc] = 1'b1;
          mFail[acc] = 0;
        end
      end
    end else begin
      mFail[acc] = 0;
      e.edges    = 4;
      case (op)
        3'd3: begin
          e.bal  = mBal[acc];
          e.succ = 1'b1;
        end
        3'd4: begin
          if ({16'd0, amt} <= mBal[acc]) begin
            mBal[acc] = mBal[acc] - {16'd0, amt};
            e.succ    = 1'b1;
          end
          e.bal = mBal[acc];
        end
        3'd5: begin
          sum = {1'b0, mBal[acc]} + {17'd0, amt};
          if (!sum[32]) begin
            mBal[acc] = sum[31:0];
            e.succ    = 1'b1;
          end
          e.bal = mBal[acc];
        end
        3'd6: begin
          if (np <= 14'd9999 && np != mPin[acc]) begin
            mPin[acc] = np;
            e.succ    = 1'b1;
          end
          e.bal = mBal[acc];
        end
        default: e.menu = 1'b1;
      endcase
    end
    mOutBal = e.bal;
    sbQ.push_back(e);

    bus.operation = op;
    bus.acc_num   = acc;
    bus.pin       = p;
    bus.newPin    = np;
    bus.amount    = amt;
    bus.language  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.operation = 3'($urandom);
    bus.acc_num   = 4'($urandom);
    bus.pin       = 14'($urandom);
    bus.newPin    = 14'($urandom);
    bus.amount    = 16'($urandom);
    edges   = 1;
    sawMenu = 1'b0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.state == 3'd2) sawMenu = 1'b1;
    end while (bus.state != 3'd7 && edges < 10);

    got = sbQ.pop_front();
    checkOutput({tag, ".success"}, 32'(bus.success), 32'(got.succ));
    checkOutput({tag, ".balance"}, bus.balance,      got.bal);
    checkOutput({tag, ".edges"},   32'(edges),       32'(got.edges));
    checkOutput({tag, ".menu"},    32'(sawMenu),     32'(got.menu));
  endtask

  initial begin
    logic [3:0]  ra;
    logic [2:0]  rop;
    logic [13:0] rp;

    nCompared     = 0;
    nMismatched   = 0;
    rst           = 1'b1;
    bus.operation = 3'd0;
    bus.acc_num   = 4'd0;
    bus.pin       = 14'd0;
    bus.newPin    = 14'd0;
    bus.amount    = 16'd0;
    bus.language  = 1'b0;
    modelReset();

    doReset("reset");

    applyStimulus("bal_acc3", 3'd3, 4'd3, 14'd3456, 14'd0, 16'd0);
    checkOutput("bal_acc3.const", bus.balance, 32'd3000);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus($sformatf("bal_all%0d", k), 3'd3, 4'(k), mPin[k], 14'd0, 16'd0);
      checkOutput($sformatf("bal_all%0d.const", k), bus.balance, 32'(k * 1000));
    end

    applyStimulus("overdraw", 3'd4, 4'd2, 14'd2345, 14'd0, 16'd2100);
    checkOutput("overdraw.const", bus.balance, 32'd2000);
    applyStimulus("deposit", 3'd5, 4'd2, 14'd2345, 14'd0, 16'd1000);
    checkOutput("deposit.const", bus.balance, 32'd3000);
    applyStimulus("withdraw", 3'd4, 4'd2, 14'd2345, 14'd0, 16'd500);
    checkOutput("withdraw.const", bus.balance, 32'd2500);
    applyStimulus("wd_zero", 3'd4, 4'd2, 14'd2345, 14'd0, 16'd0);
    applyStimulus("dep_zero", 3'd5, 4'd2, 14'd2345, 14'd0, 16'd0);
    applyStimulus("wd_exact", 3'd4, 4'd5, 14'd5678, 14'd0, 16'd5000);
    checkOutput("wd_exact.const", bus.balance, 32'd0);
    applyStimulus("bal_after", 3'd3, 4'd2, 14'd2345, 14'd0, 16'd0);

    for (int a = 11; a <= 15; a++) begin
      applyStimulus($sformatf("bad_acc%0d", a), 3'd3, 4'(a), 14'd1234, 14'd0, 16'd0);
    end
    applyStimulus("bad_acc0", 3'd3, 4'd0, 14'd1234, 14'd0, 16'd0);
    applyStimulus("bad_pin", 3'd4, 4'd1, 14'd7123, 14'd0, 16'd100);

    applyStimulus("pin_same", 3'd6, 4'd1, 14'd1234, 14'd1234, 16'd0);
    applyStimulus("pin_big", 3'd6, 4'd1, 14'd1234, 14'd10000, 16'd0);
    applyStimulus("pin_max", 3'd6, 4'd7, 14'd7890, 14'd9999, 16'd0);
    applyStimulus("pin_chg", 3'd6, 4'd1, 14'd1234, 14'd5678, 16'd0);
    checkOutput("pin_chg.const", 32'(bus.success), 32'd1);
    applyStimulus("pin_old", 3'd3, 4'd1, 14'd1234, 14'd0, 16'd0);
    applyStimulus("pin_new", 3'd3, 4'd1, 14'd5678, 14'd0, 16'd0);
    checkOutput("pin_new.const", bus.balance, 32'd1000);

    applyStimulus("op7", 3'd7, 4'd3, 14'd3456, 14'd0, 16'd0);
    applyStimulus("op0", 3'd0, 4'd3, 14'd3456, 14'd0, 16'd0);
    applyStimulus("op2", 3'd2, 4'd6, 14'd6789, 14'd0, 16'd0);

    for (int t = 0; t < 3; t++) begin
      applyStimulus($sformatf("lock_wrong%0d", t), 3'd3, 4'd4, 14'd1111, 14'd0, 16'd0);
    end
    applyStimulus("lock_right", 3'd3, 4'd4, 14'd4567, 14'd0, 16'd0);
    applyStimulus("lock_again", 3'd5, 4'd4, 14'd4567, 14'd0, 16'd10);

    // Abort a withdraw mid-flight with reset
    bus.operation = 3'd4;
    bus.acc_num   = 4'd3;
    bus.pin       = 14'd3456;
    bus.amount    = 16'd100;
    @(posedge clk);
    @(posedge clk);
    doReset("midreset");
    applyStimulus("post_reset4", 3'd3, 4'd4, 14'd4567, 14'd0, 16'd0);
    applyStimulus("post_reset3", 3'd3, 4'd3, 14'd3456, 14'd0, 16'd0);
    checkOutput("post_reset3.const", bus.balance, 32'd3000);

    for (int t = 0; t < 25; t++) begin
      ra  = 4'($urandom_range(1, 12));
      rop = 3'($urandom_range(2, 7));
      rp  = ($urandom_range(0, 3) != 0 && ra <= 4'd10) ? mPin[ra] : 14'($urandom_range(0, 9999));
      applyStimulus($sformatf("rand%0d", t), rop, ra, rp,
                    14'($urandom_range(0, 10100)), 16'($urandom_range(0, 3000)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
